// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types, parity-mode constants and parameter checks
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP
    } state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    function automatic bit data_bits_ok(input int n);
        return (n >= 5) && (n <= 8);
    endfunction

    function automatic bit parity_ok(input int p);
        return (p == PAR_NONE) || (p == PAR_EVEN) || (p == PAR_ODD);
    endfunction

    function automatic bit stop_bits_ok(input int s);
        return (s == 1) || (s == 2);
    endfunction

    function automatic bit cfg_ok(input int db, input int par, input int sb);
        return data_bits_ok(db) && parity_ok(par) && stop_bits_ok(sb);
    endfunction

endpackage

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmitter: start, data LSB first, optional parity, stop bits
module uart_tx
    import uart_pkg::*;
#(
    parameter int N         = 13,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = PAR_NONE,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         q,
    input  logic                 tx_start,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx,
    output logic                 busy,
    output logic                 tx_done,
    output logic                 presc_sync
);

    if (!cfg_ok(DATA_BITS, PARITY, STOP_BITS)) begin : g_bad_cfg
        $error("uart_tx: illegal DATA_BITS/PARITY/STOP_BITS combination");
    end

    localparam logic [2:0] LAST_DATA = 3'(DATA_BITS - 1);
    localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);
    localparam bit         HAS_PAR   = (PARITY != PAR_NONE);
    localparam bit         ODD_PAR   = (PARITY == PAR_ODD);

    state_t                 state, state_n;
    logic [DATA_BITS-1:0]   shreg, shreg_n;
    logic [2:0]             cnt, cnt_n;
    logic                   tx_n, done_n, sync_n;
    logic                   bit_tick;

    // The prescaler is being restarted while presc_sync is high, so its q is stale then.
    assign bit_tick = (q == '0) && !presc_sync;
    assign busy     = (state != IDLE);

    // State and output registers; reset returns the line high at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            shreg      <= '0;
            cnt        <= '0;
            tx         <= 1'b1;
            tx_done    <= 1'b0;
            presc_sync <= 1'b0;
        end else begin
            state      <= state_n;
            shreg      <= shreg_n;
            cnt        <= cnt_n;
            tx         <= tx_n;
            tx_done    <= done_n;
            presc_sync <= sync_n;
        end
    end

    // Next-state logic; the shift register rotates so the captured word is intact for parity.
    always_comb begin
        state_n = state;
        shreg_n = shreg;
        cnt_n   = cnt;
        tx_n    = tx;
        done_n  = 1'b0;
        sync_n  = 1'b0;
        case (state)
            IDLE: begin
                tx_n = 1'b1;
                if (tx_start) begin
                    state_n = START;
                    tx_n    = 1'b0;
                    shreg_n = tx_data;
                    cnt_n   = '0;
                    sync_n  = 1'b1;
                end
            end
            START: begin
                if (bit_tick) begin
                    state_n = DATA;
                    tx_n    = shreg[0];
                end
            end
            DATA: begin
                if (bit_tick) begin
                    shreg_n = {shreg[0], shreg[DATA_BITS-1:1]};
                    if (cnt == LAST_DATA) begin
                        cnt_n = '0;
                        if (HAS_PAR) begin
                            state_n = PAR;
                            tx_n    = (^shreg) ^ ODD_PAR;
                        end else begin
                            state_n = STOP;
                            tx_n    = 1'b1;
                        end
                    end else begin
                        cnt_n = cnt + 3'd1;
                        tx_n  = shreg[1];
                    end
                end
            end
            PAR: begin
                if (bit_tick) begin
                    state_n = STOP;
                    tx_n    = 1'b1;
                    cnt_n   = '0;
                end
            end
            STOP: begin
                tx_n = 1'b1;
                if (bit_tick) begin
                    if (cnt == LAST_STOP) begin
                        state_n = IDLE;
                        cnt_n   = '0;
                        done_n  = 1'b1;
                    end else begin
                        cnt_n = cnt + 3'd1;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                tx_n    = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - scoreboard bench for uart_tx across four frame formats
module tb_uart_tx;
    import uart_pkg::*;

    localparam int B  = 4;
    localparam int NW = 3;
    localparam int NI = 4;

    typedef struct {
        int         g;
        logic [7:0] d;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [NW-1:0]   q [NI];
    logic [NI-1:0]   tx_start = '0;
    logic [7:0]      tx_data [NI];
    logic [NI-1:0]   tx, busy, tx_done, presc_sync;

    int checks = 0;
    int errors = 0;
    exp_t exp_q [$];

    int          cyc_now = 0;
    bit          active   [NI];
    int          fcyc     [NI];
    int          flen     [NI];
    int          ferr     [NI];
    logic [63:0] trace    [NI];
    int          done_cnt [NI];
    int          done_cyc [NI];
    int          start_cyc[NI];
    int          busy_run [NI];
    int          last_len [NI];
    int          sent     [NI];
    int          aborted  [NI];

    uart_tx #(.N(NW), .DATA_BITS(8), .PARITY(PAR_NONE), .STOP_BITS(1)) u_8n1 (
        .clk(clk), .rst(rst), .q(q[0]), .tx_start(tx_start[0]), .tx_data(tx_data[0]),
        .tx(tx[0]), .busy(busy[0]), .tx_done(tx_done[0]), .presc_sync(presc_sync[0]));
    uart_tx #(.N(NW), .DATA_BITS(8), .PARITY(PAR_EVEN), .STOP_BITS(1)) u_8e1 (
        .clk(clk), .rst(rst), .q(q[1]), .tx_start(tx_start[1]), .tx_data(tx_data[1]),
        .tx(tx[1]), .busy(busy[1]), .tx_done(tx_done[1]), .presc_sync(presc_sync[1]));
    uart_tx #(.N(NW), .DATA_BITS(8), .PARITY(PAR_ODD), .STOP_BITS(1)) u_8o1 (
        .clk(clk), .rst(rst), .q(q[2]), .tx_start(tx_start[2]), .tx_data(tx_data[2]),
        .tx(tx[2]), .busy(busy[2]), .tx_done(tx_done[2]), .presc_sync(presc_sync[2]));
    uart_tx #(.N(NW), .DATA_BITS(5), .PARITY(PAR_NONE), .STOP_BITS(2)) u_5n2 (
        .clk(clk), .rst(rst), .q(q[3]), .tx_start(tx_start[3]), .tx_data(tx_data[3][4:0]),
        .tx(tx[3]), .busy(busy[3]), .tx_done(tx_done[3]), .presc_sync(presc_sync[3]));

    initial forever #5 clk = ~clk;

    // Prescaler: counts B..0, reloads after zero or on a restart pulse.
    always @(posedge clk or negedge rst) begin
        for (int g = 0; g < NI; g++) begin
            if (!rst)                              q[g] <= NW'(B);
            else if (presc_sync[g] || q[g] == '0)  q[g] <= NW'(B);
            else                                   q[g] <= q[g] - 1'b1;
        end
    end

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Expected line level for every cycle of a frame, from the frame rules.
    function automatic void make_trace(input int g, input logic [7:0] d,
                                       output logic [63:0] t, output int len);
        int nb, pm, sb, ones;
        bit lvl [$];
        int dur [$];
        nb = (g == 3) ? 5 : 8;
        pm = (g == 1) ? 1 : (g == 2) ? 2 : 0;
        sb = (g == 3) ? 2 : 1;
        ones = 0;
        lvl.push_back(1'b0); dur.push_back(B + 2);
        for (int i = 0; i < nb; i++) begin
            lvl.push_back(d[i]); dur.push_back(B + 1);
            ones += int'(d[i]);
        end
        if (pm != 0) begin
            lvl.push_back(((ones % 2) == 1) != (pm == 2)); dur.push_back(B + 1);
        end
        lvl.push_back(1'b1); dur.push_back(sb * (B + 1));
        t = '1;
        len = 0;
        foreach (lvl[k]) begin
            repeat (dur[k]) begin
                t[len] = lvl[k];
                len++;
            end
        end
    endfunction

    // Monitor: each new busy period pops the next expected word and is checked cycle by cycle.
    always @(negedge clk) begin
        int idx;
        cyc_now++;
        for (int g = 0; g < NI; g++) begin
            if (!rst) begin
                active[g]   = 1'b0;
                busy_run[g] = 0;
            end else begin
                if (tx_done[g]) begin
                    done_cnt[g]++;
                    done_cyc[g] = cyc_now;
                end
                if (busy[g]) busy_run[g]++;
                else if (busy_run[g] != 0) begin
                    last_len[g] = busy_run[g];
                    busy_run[g] = 0;
                end
                if (!active[g] && busy[g]) begin
                    idx = -1;
                    for (int i = 0; i < exp_q.size(); i++) begin
                        if (exp_q[i].g == g) begin
                            idx = i;
                            break;
                        end
                    end
                    chk($sformatf("frame_expected_%0d", g), idx >= 0, 1);
                    if (idx >= 0) begin
                        make_trace(g, exp_q[idx].d, trace[g], flen[g]);
                        exp_q.delete(idx);
                        active[g]    = 1'b1;
                        fcyc[g]      = 0;
                        ferr[g]      = 0;
                        start_cyc[g] = cyc_now;
                    end
                end
                if (active[g]) begin
                    if (fcyc[g] < flen[g]) begin
                        if (tx[g] !== trace[g][fcyc[g]] || busy[g] !== 1'b1 || tx_done[g] !== 1'b0)
                            ferr[g]++;
                        fcyc[g]++;
                    end else begin
                        chk($sformatf("frame_line_%0d", g), ferr[g], 0);
                        chk($sformatf("frame_end_busy_done_%0d", g), {busy[g], tx_done[g]}, 2'b01);
                        active[g] = 1'b0;
                    end
                end
            end
        end
    end

    task automatic wait_idle(input int g);
        int n;
        n = 0;
        while (busy[g] && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("idle_timeout_%0d", g), busy[g], 0);
    endtask

    task automatic send(input int g, input logic [7:0] d);
        wait_idle(g);
        tx_data[g]  = d;
        tx_start[g] = 1'b1;
        exp_q.push_back('{g, d});
        sent[g]++;
        @(negedge clk);
        tx_start[g] = 1'b0;
    endtask

    initial begin
        int n, hi, g, pend;
        logic [7:0] w1, w2, d;
        for (int i = 0; i < NI; i++) tx_data[i] = '0;

        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_tx", tx, 4'hF);
        chk("reset_busy", busy, 0);
        chk("reset_done", tx_done, 0);
        chk("reset_sync", presc_sync, 0);
        #2 rst = 1'b1;

        // 0xA5 on 8N1, 8E1, 8O1 together.
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            tx_data[i] = 8'hA5;
            exp_q.push_back('{i, 8'hA5});
            sent[i]++;
        end
        tx_start[2:0] = 3'b111;
        @(negedge clk);
        tx_start = '0;
        chk("accept_tx_low", tx[2:0], 0);
        chk("accept_busy", busy[2:0], 7);
        chk("presc_sync_pulse", presc_sync[2:0], 7);
        @(negedge clk);
        chk("presc_sync_one_cycle", presc_sync[2:0], 0);
        repeat (47) @(negedge clk);
        chk("a5_8n1_stop_at_48", tx[0], 1);
        chk("a5_even_parity", tx[1], 0);
        chk("a5_odd_parity", tx[2], 1);
        for (int i = 0; i < 3; i++) wait_idle(i);
        @(negedge clk);
        chk("len_8n1", last_len[0], 51);
        chk("len_8e1", last_len[1], 56);
        chk("len_8o1", last_len[2], 56);

        // tx_start held high across two frames.
        @(negedge clk);
        w1 = 8'($urandom);
        w2 = 8'($urandom);
        tx_data[0] = w1; tx_start[0] = 1'b1;
        exp_q.push_back('{0, w1}); sent[0]++;
        @(negedge clk);
        tx_data[0] = w2;
        exp_q.push_back('{0, w2}); sent[0]++;
        n = 0;
        while (!tx_done[0] && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("b2b_first_done", tx_done[0], 1);
        @(negedge clk);
        tx_start[0] = 1'b0;
        chk("b2b_restart_busy", busy[0], 1);
        @(negedge clk);
        chk("b2b_gap", start_cyc[0] - done_cyc[0], 1);
        wait_idle(0);

        // tx_start pulse during DATA must be ignored.
        send(0, 8'($urandom));
        repeat (20) @(negedge clk);
        tx_data[0] = 8'($urandom); tx_start[0] = 1'b1;
        @(negedge clk);
        tx_start[0] = 1'b0;
        wait_idle(0);

        // Reset during the third data bit, then a 0x3C frame.
        send(0, 8'($urandom));
        repeat (17) @(negedge clk);
        #2 rst = 1'b0;
        aborted[0]++;
        #1;
        chk("abort_tx_high", tx[0], 1);
        chk("abort_busy_low", busy[0], 0);
        chk("abort_no_done", tx_done[0], 0);
        tx_data[0] = 8'h3C; tx_start[0] = 1'b1;
        repeat (2) @(negedge clk);
        exp_q.push_back('{0, 8'h3C}); sent[0]++;
        #2 rst = 1'b1;
        @(negedge clk);
        chk("first_edge_accept", busy[0], 1);
        tx_start[0] = 1'b0;
        wait_idle(0);

        // 5N2 with 0x1F.
        send(3, 8'h1F);
        repeat (31) @(negedge clk);
        hi = 0;
        for (int k = 0; k < 10; k++) begin
            if (tx[3] === 1'b1) hi++;
            @(negedge clk);
        end
        chk("5n2_last10_high", hi, 10);
        wait_idle(3);
        @(negedge clk);
        chk("len_5n2", last_len[3], 41);

        // Random frames on random formats.
        repeat (24) begin
            g = $urandom_range(0, NI - 1);
            d = 8'($urandom);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            send(g, d);
        end

        for (int i = 0; i < NI; i++) wait_idle(i);
        repeat (3) @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("done_count_%0d", i), done_cnt[i], sent[i] - aborted[i]);
            pend = 0;
            foreach (exp_q[k]) if (exp_q[k].g == i) pend++;
            chk($sformatf("pending_%0d", i), pend, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 The block SHALL have parameter N, default 13, the width of the prescaler count input.
REQ-002 The block SHALL have parameter DATA_BITS, default 8, the data bits per frame, legal range 5..8.
REQ-003 The block SHALL have parameter PARITY, default 0, selecting the parity bit: 0 none, 1 even, 2 odd.
REQ-004 The block SHALL have parameter STOP_BITS, default 1, the stop bits per frame, legal values 1 or 2.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all flops on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port q, input, N bits: the prescaler down-count; the bit tick is q == 0.
REQ-008 The block SHALL have port tx_start, input, 1 bit: a frame request, sampled when idle.
REQ-009 The block SHALL have port tx_data, input, DATA_BITS bits: the frame payload, captured at acceptance.
REQ-010 The block SHALL have port tx, output, 1 bit: the serial line, registered, idle high.
REQ-011 The block SHALL have port busy, output, 1 bit: high from acceptance through the end of the last stop bit.
REQ-012 The block SHALL have port tx_done, output, 1 bit: a one-cycle pulse at frame end.
REQ-013 The block SHALL have port presc_sync, output, 1 bit: an active-high synchronous restart pulse to the prescaler rst.

Function
REQ-014 The FSM SHALL use states IDLE, START, DATA, PAR, STOP; PAR is skipped when PARITY == 0.
REQ-015 In IDLE with tx_start=1 at cycle T, the block SHALL at edge T+1 enter START, drive tx=0 and busy=1, latch tx_data into a shift register, and assert presc_sync for cycle T+1 only.
REQ-016 bit_tick SHALL be q == 0 and SHALL be masked while presc_sync=1.
REQ-017 Timing consequence: with prescaler load value B, the start bit SHALL last B+2 cycles; every later bit SHALL last B+1 cycles.
REQ-018 On each unmasked bit_tick the FSM SHALL advance one bit; all transitions SHALL occur at the edge following the tick cycle.
REQ-019 START SHALL go to DATA; DATA SHALL shift LSB first.
REQ-020 A bit counter SHALL leave DATA after DATA_BITS ticks for PAR, or for STOP when PARITY == 0.
REQ-021 The PAR bit SHALL be the XOR of the latched data for even parity and its inverse for odd parity, computed from the captured copy and unaffected by tx_data changes mid-frame.
REQ-022 STOP SHALL drive tx=1 for STOP_BITS bit periods.
REQ-023 On the final STOP tick the block SHALL, at the next edge, enter IDLE with busy=0 and tx_done=1 for one cycle.
REQ-024 tx_start while busy=1 SHALL be ignored, with no queuing.
REQ-025 tx_start asserted in the tx_done cycle SHALL be accepted, since the state is IDLE then.
REQ-026 A back-to-back frame SHALL add no idle cycles beyond that acceptance cycle.
REQ-027 In IDLE, q SHALL be ignored and tx SHALL stay 1.
REQ-028 The counter width SHALL be 3 bits, and it SHALL not wrap within a frame.

Reset
REQ-029 rst=0 SHALL immediately force IDLE, tx=1, busy=0, tx_done=0, presc_sync=0, counters 0, and shift register 0.
REQ-030 Reset mid-frame SHALL abort the frame with no tx_done, and the line SHALL return high asynchronously.
REQ-031 After rst deasserts, the first tx_start SHALL be accepted on the first rising edge.

Structure
REQ-032 A shared package uart_pkg SHALL hold the state enum, the parity-mode constants (PAR_NONE, PAR_EVEN, PAR_ODD), and the legal-range checks.
REQ-033 No sub-module SHALL be required; the prescaler SHALL remain a sibling instance in uart_top, with q and presc_sync wired directly.

Verification (bench: prescaler load B=4, N=3)
REQ-034 A bench SHALL cover: tx_start with tx_data=0xA5, 8N1 -> tx = 0 (6 cycles), then 1,0,1,0,0,1,0,1 (5 cycles each), then stop 1 (5 cycles); tx_done pulses once; busy high 51 cycles.
REQ-035 A bench SHALL cover: 0xA5 with PARITY=1 -> parity bit 0; with PARITY=2 -> parity bit 1; frame length 56 cycles.
REQ-036 A bench SHALL cover: tx_start held high continuously with two data words -> the second start bit begins exactly one cycle after the first tx_done, and no frame is dropped or duplicated.
REQ-037 A bench SHALL cover: tx_start pulsed during the DATA state of a frame -> ignored, with exactly one tx_done.
REQ-038 A bench SHALL cover: rst=0 asserted during the third data bit -> tx=1 and busy=0 asynchronously, with no tx_done; a new 0x3C frame after release is correct.
REQ-039 A bench SHALL cover: STOP_BITS=2, DATA_BITS=5, data 0x1F -> 1+5+2 bit periods, with the line high for the last 10 cycles.
